crc_serial_engine: RTL and testbench
====================================

// Module: crc_serial_engine
// PURPOSE
//  Parametrised serial CRC engine: absorbs a bit-serial frame through a Galois LFSR (CRC_W bits, TAPS, SEED).
//  Generate mode: after the frame, streams the CRC out LSB-first with Valid.
//  Check mode: after the frame, compares the next CRC_W received DATA bits against the computed CRC and flags ERR.
//  Sits between the serial framer and the line interface; successor to the fixed 8-bit generator, adding width, check mode, XOR-out and auto-reseed.
// PARAMETERS
//  CRC_W    8             LFSR/CRC width, 2..32
//  TAPS     8'b10001000   tap mask; TAPS[k]=1 -> LFSR[k-1] <= LFSR[k]^fb
//  SEED     8'hD8         LFSR load value at reset and at every frame start
//  XOR_OUT  8'h00         XORed onto the CRC before output/compare
// PORTS
//  CLK        in   1      clock, rising edge
//  RST        in   1      synchronous reset, active-high
//  DATA       in   1      frame bit while ACTIVE=1; received CRC bit during check phase
//  ACTIVE     in   1      frame qualifier; 1 = absorb DATA this cycle
//  MODE       in   1      0 = generate, 1 = check; sampled on first ACTIVE cycle of a frame
//  CRC        out  1      serial CRC bit (generate mode), LSB first
//  Valid      out  1      CRC bit valid
//  DONE       out  1      1-cycle pulse: output/check phase complete
//  ERR        out  1      check result, meaningful only with DONE; 1 = mismatch
//  BUSY       out  1      1 while in ABSORB/EMIT/CHECK
//  CRC_VALUE  out  CRC_W  parallel LFSR^XOR_OUT, registered, updated on frame end
// BEHAVIOUR
//  Reset: LFSR=SEED, state IDLE, counter=0; CRC, Valid, DONE, ERR, BUSY = 0; CRC_VALUE=0.
//  fb = LFSR[0]^DATA (combinational). Absorb step: LFSR[CRC_W-1]<=fb; for k=CRC_W-1..1:
//   LFSR[k-1] <= TAPS[k] ? LFSR[k]^fb : LFSR[k].
//  FSM: IDLE, ABSORB, EMIT, CHECK.
//  IDLE: ACTIVE=1 -> latch MODE; absorb DATA starting from SEED (LFSR already SEED); -> ABSORB.
//  ABSORB: ACTIVE=1 -> absorb. ACTIVE=0 -> no absorb; CRC_VALUE<=LFSR^XOR_OUT; counter=0;
//   -> EMIT (mode 0) or CHECK (mode 1).
//  EMIT: each cycle CRC=LFSR[0]^XOR_OUT[counter], Valid=1, LFSR shifts right (MSB<=0).
//   Exactly CRC_W cycles with Valid=1 (including the last bit). On cycle after last bit:
//   Valid=0, DONE=1, ERR=0, LFSR<=SEED, -> IDLE.
//  CHECK: each cycle compare DATA with LFSR[0]^XOR_OUT[counter]; mismatch sets sticky err;
//   LFSR shifts right. After CRC_W bits: DONE=1, ERR=err (incl. last bit), LFSR<=SEED, -> IDLE.
//   CRC/Valid stay 0 in check mode.
//  Latency: first CRC bit with Valid appears 1 cycle after the first ACTIVE=0 cycle.
//  ACTIVE=1 during EMIT/CHECK: abort phase, no DONE, Valid=0, LFSR reseeded and this
//   DATA bit absorbed from SEED, MODE re-latched -> ABSORB.
//  ACTIVE=1 on the cycle DONE is asserted is a new frame start (IDLE rules apply next cycle).
//  RST=1 in any state overrides all; mid-frame state is discarded.
//  counter width $clog2(CRC_W)+1; never wraps before CRC_W.
// STRUCTURE
//  Shared package crc_pkg: state enum (IDLE/ABSORB/EMIT/CHECK), default CRC8 TAPS/SEED constants.
//  Sub-module crc_lfsr_step: combinational next-LFSR for one absorbed bit (CRC_W, TAPS);
//   FSM, counter and output registers stay in crc_serial_engine.
// TESTING (defaults, XOR_OUT=0)
//  1 gen: ACTIVE=1 for 1 cycle, DATA=0 -> CRC_VALUE=8'h6C; CRC bits 0,0,1,1,0,1,1,0, Valid 8 cycles, DONE.
//  2 gen: ACTIVE=1 for 1 cycle, DATA=1 -> CRC_VALUE=8'hA8; serial 0,0,0,1,0,1,0,1; DONE, ERR=0.
//  3 check: MODE=1, frame DATA=0, then DATA=0,0,1,1,0,1,1,0 -> DONE with ERR=0; flip last bit -> ERR=1.
//  4 abort: ACTIVE=1 at 3rd EMIT cycle -> Valid drops, no DONE, new frame CRC matches ref model from SEED.
//  5 back-to-back: two 1-bit DATA=0 frames, second ACTIVE on DONE cycle -> both CRC_VALUE=8'h6C.
//  6 reset mid-EMIT: RST=1 one cycle -> all outputs 0 next cycle, next frame DATA=1 gives 8'hA8.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared types and default CRC8 constants for the serial CRC engine.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ABSORB,
    EMIT,
    CHECK
  } crc_state_t;

  localparam logic [7:0] CRC8_TAPS    = 8'b10001000;
  localparam logic [7:0] CRC8_SEED    = 8'hD8;
  localparam logic [7:0] CRC8_XOR_OUT = 8'h00;

endpackage

// File: rtl/crc_lfsr_step.sv
// Combinational next state of the Galois LFSR after absorbing one serial bit.
module crc_lfsr_step
  import crc_pkg::*;
#(
  parameter int               CRC_W = 8,
  parameter logic [CRC_W-1:0] TAPS  = CRC_W'(CRC8_TAPS)
) (
  input  logic [CRC_W-1:0] lfsr,
  input  logic             data,
  output logic [CRC_W-1:0] lfsr_next
);

  logic fb;

  always_comb begin
    fb = lfsr[0] ^ data;
    lfsr_next = '0;
    lfsr_next[CRC_W-1] = fb;
    for (int k = CRC_W - 1; k >= 1; k--) begin
      lfsr_next[k-1] = TAPS[k] ? (lfsr[k] ^ fb) : lfsr[k];
    end
  end

endmodule

// File: rtl/crc_serial_engine.sv
// Serial CRC engine: absorbs a bit-serial frame, then either streams the CRC
// out LSB-first (generate) or compares the following received bits (check).
module crc_serial_engine
  import crc_pkg::*;
#(
  parameter int               CRC_W   = 8,
  parameter logic [CRC_W-1:0] TAPS    = CRC_W'(CRC8_TAPS),
  parameter logic [CRC_W-1:0] SEED    = CRC_W'(CRC8_SEED),
  parameter logic [CRC_W-1:0] XOR_OUT = CRC_W'(CRC8_XOR_OUT)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             DATA,
  input  logic             ACTIVE,
  input  logic             MODE,
  output logic             CRC,
  output logic             Valid,
  output logic             DONE,
  output logic             ERR,
  output logic             BUSY,
  output logic [CRC_W-1:0] CRC_VALUE
);

  localparam int               CNT_W = $clog2(CRC_W) + 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CRC_W - 1);

  crc_state_t       state;
  logic [CRC_W-1:0] lfsr;
  logic [CRC_W-1:0] xor_sh;
  logic [CRC_W-1:0] lfsr_absorb;
  logic [CRC_W-1:0] seed_absorb;
  logic [CNT_W-1:0] cnt;
  logic             mode_q;
  logic             err_q;
  logic             out_bit;
  logic             mismatch;

  crc_lfsr_step #(.CRC_W(CRC_W), .TAPS(TAPS)) u_step_cur (
    .lfsr      (lfsr),
    .data      (DATA),
    .lfsr_next (lfsr_absorb)
  );

  // An abort restarts the frame from SEED, so its first bit is absorbed into SEED.
  crc_lfsr_step #(.CRC_W(CRC_W), .TAPS(TAPS)) u_step_seed (
    .lfsr      (SEED),
    .data      (DATA),
    .lfsr_next (seed_absorb)
  );

  // xor_sh shifts alongside the LFSR so bit 0 always lines up with the current CRC bit.
  assign out_bit  = lfsr[0] ^ xor_sh[0];
  assign mismatch = DATA ^ out_bit;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      lfsr      <= SEED;
      xor_sh    <= '0;
      cnt       <= '0;
      mode_q    <= 1'b0;
      err_q     <= 1'b0;
      CRC       <= 1'b0;
      Valid     <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
      BUSY      <= 1'b0;
      CRC_VALUE <= '0;
    end else begin
      DONE <= 1'b0;
      ERR  <= 1'b0;
      case (state)
        IDLE: begin
          if (ACTIVE) begin
            mode_q <= MODE;
            lfsr   <= lfsr_absorb;
            BUSY   <= 1'b1;
            state  <= ABSORB;
          end
        end

        ABSORB: begin
          if (ACTIVE) begin
            lfsr <= lfsr_absorb;
          end else begin
            CRC_VALUE <= lfsr ^ XOR_OUT;
            xor_sh    <= XOR_OUT;
            cnt       <= '0;
            err_q     <= 1'b0;
            if (mode_q) begin
              state <= CHECK;
            end else begin
              CRC   <= lfsr[0] ^ XOR_OUT[0];
              Valid <= 1'b1;
              state <= EMIT;
            end
          end
        end

        EMIT, CHECK: begin
          if (ACTIVE) begin
            CRC    <= 1'b0;
            Valid  <= 1'b0;
            mode_q <= MODE;
            lfsr   <= seed_absorb;
            state  <= ABSORB;
          end else if (cnt == LAST) begin
            CRC   <= 1'b0;
            Valid <= 1'b0;
            DONE  <= 1'b1;
            ERR   <= (state == CHECK) && (err_q || mismatch);
            lfsr  <= SEED;
            BUSY  <= 1'b0;
            state <= IDLE;
          end else begin
            lfsr   <= {1'b0, lfsr[CRC_W-1:1]};
            xor_sh <= {1'b0, xor_sh[CRC_W-1:1]};
            cnt    <= cnt + 1'b1;
            if (state == CHECK) begin
              err_q <= err_q || mismatch;
            end else begin
              CRC <= lfsr[1] ^ xor_sh[1];
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_serial_engine.sv
// Randomised self-checking bench for crc_serial_engine against a polynomial reference model.
module tb_crc_serial_engine;

  localparam logic [7:0] M_TAPS = 8'b10001000;
  localparam logic [7:0] M_SEED = 8'hD8;
  localparam logic [7:0] M_XOR  = 8'h00;

  logic       clk = 1'b0;
  logic       rst;
  logic       data;
  logic       active;
  logic       mode;
  logic       crc;
  logic       valid;
  logic       done;
  logic       err;
  logic       busy;
  logic [7:0] crc_value;

  int errors = 0;
  int checks = 0;

  bit   frame_bits[64];
  int   frame_len;
  logic frame_mode;

  crc_serial_engine dut (
    .CLK       (clk),
    .RST       (rst),
    .DATA      (data),
    .ACTIVE    (active),
    .MODE      (mode),
    .CRC       (crc),
    .Valid     (valid),
    .DONE      (done),
    .ERR       (err),
    .BUSY      (busy),
    .CRC_VALUE (crc_value)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference CRC: polynomial division form, feedback folded in as a whole-word XOR.
  function automatic logic [7:0] modelCrc();
    logic [7:0] r;
    logic       fb;
    r = M_SEED;
    for (int i = 0; i < frame_len; i++) begin
      fb = r[0] ^ frame_bits[i];
      r  = (r >> 1) ^ (fb ? ((M_TAPS >> 1) | 8'h80) : 8'h00);
    end
    return r ^ M_XOR;
  endfunction

  task automatic driveBits(input int from);
    for (int i = from; i < frame_len; i++) begin
      mode   = frame_mode;
      data   = frame_bits[i];
      active = 1'b1;
      tick();
      checkOutput("busy_absorb", 32'(busy), 32'd1);
    end
    active = 1'b0;
    data   = 1'b0;
    tick();
  endtask

  // Finishes the frame and leaves the bench sitting in the DONE cycle.
  task automatic finishFrame(input logic [7:0] rx);
    logic [7:0] exp_crc;
    logic [7:0] ser;
    int         vcnt;
    int         early_done;
    exp_crc    = modelCrc();
    ser        = '0;
    vcnt       = 0;
    early_done = 0;
    checkOutput("crc_value_frame_end", 32'(crc_value), 32'(exp_crc));
    for (int j = 0; j < 8; j++) begin
      if (frame_mode) data = rx[j];
      ser[j] = crc;
      vcnt += int'(valid);
      early_done += int'(done);
      tick();
    end
    data = 1'b0;
    if (frame_mode) begin
      checkOutput("chk_valid_cnt", 32'(vcnt), 32'd0);
      checkOutput("chk_err", 32'(err), 32'(rx != exp_crc));
    end else begin
      checkOutput("gen_serial", 32'(ser), 32'(exp_crc));
      checkOutput("gen_valid_cnt", 32'(vcnt), 32'd8);
      checkOutput("gen_err", 32'(err), 32'd0);
    end
    checkOutput("early_done", 32'(early_done), 32'd0);
    checkOutput("done_pulse", 32'(done), 32'd1);
    checkOutput("valid_after", 32'(valid), 32'd0);
    checkOutput("busy_after", 32'(busy), 32'd0);
  endtask

  task automatic applyStimulus(input logic m, input logic [7:0] rx);
    frame_mode = m;
    driveBits(0);
    finishFrame(rx);
  endtask

  task automatic idleCycle();
    active = 1'b0;
    data   = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0] exp;
    logic [7:0] rx;
    bit         corrupt;
    rst    = 1'b1;
    data   = 1'b0;
    active = 1'b0;
    mode   = 1'b0;
    tick();
    tick();
    checkOutput("rst_valid", 32'(valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_crc_value", 32'(crc_value), 32'd0);
    rst = 1'b0;
    idleCycle();

    $display("[TB] single zero bit, generate");
    frame_len = 1; frame_bits[0] = 1'b0;
    applyStimulus(1'b0, 8'h00);
    checkOutput("gen0_value", 32'(crc_value), 32'h6C);
    idleCycle();
    checkOutput("done_drops", 32'(done), 32'd0);

    $display("[TB] single one bit, generate");
    frame_len = 1; frame_bits[0] = 1'b1;
    applyStimulus(1'b0, 8'h00);
    checkOutput("gen1_value", 32'(crc_value), 32'hA8);
    idleCycle();

    $display("[TB] check mode, good and corrupted");
    frame_len = 1; frame_bits[0] = 1'b0;
    applyStimulus(1'b1, 8'h6C);
    checkOutput("chk_good_err", 32'(err), 32'd0);
    idleCycle();
    applyStimulus(1'b1, 8'hEC);
    checkOutput("chk_bad_err", 32'(err), 32'd1);
    idleCycle();

    $display("[TB] abort during emit");
    frame_len = 1; frame_bits[0] = 1'b0; frame_mode = 1'b0;
    driveBits(0);
    tick();
    tick();
    checkOutput("abort_pre_valid", 32'(valid), 32'd1);
    frame_len = $urandom_range(2, 12);
    for (int i = 0; i < frame_len; i++) frame_bits[i] = 1'($urandom);
    mode   = 1'b0;
    data   = frame_bits[0];
    active = 1'b1;
    tick();
    checkOutput("abort_valid", 32'(valid), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd1);
    driveBits(1);
    finishFrame(8'h00);
    idleCycle();

    $display("[TB] back-to-back frames");
    frame_len = 1; frame_bits[0] = 1'b0;
    applyStimulus(1'b0, 8'h00);
    checkOutput("b2b_first", 32'(crc_value), 32'h6C);
    applyStimulus(1'b0, 8'h00);
    checkOutput("b2b_second", 32'(crc_value), 32'h6C);
    idleCycle();

    $display("[TB] reset mid-emit");
    frame_len = 1; frame_bits[0] = 1'b0; frame_mode = 1'b0;
    driveBits(0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_mid_valid", 32'(valid), 32'd0);
    checkOutput("rst_mid_crc", 32'(crc), 32'd0);
    checkOutput("rst_mid_done", 32'(done), 32'd0);
    checkOutput("rst_mid_err", 32'(err), 32'd0);
    checkOutput("rst_mid_busy", 32'(busy), 32'd0);
    checkOutput("rst_mid_value", 32'(crc_value), 32'd0);
    frame_len = 1; frame_bits[0] = 1'b1;
    applyStimulus(1'b0, 8'h00);
    checkOutput("rst_next_value", 32'(crc_value), 32'hA8);
    idleCycle();

    $display("[TB] random frames");
    for (int n = 0; n < 24; n++) begin
      frame_len = $urandom_range(1, 24);
      for (int i = 0; i < frame_len; i++) frame_bits[i] = 1'($urandom);
      exp     = modelCrc();
      corrupt = 1'($urandom);
      rx      = corrupt ? (exp ^ (8'h01 << $urandom_range(0, 7))) : exp;
      applyStimulus(1'($urandom), rx);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) idleCycle();
    end

    idleCycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
